// File: rtl/io_bus_bridge.sv
// Memory-mapped I/O bridge between the cpu byte bus, the 128 KB RAM and the UART.
// Contains a TX byte FIFO, console input, a cycle counter with snapshot reads, and stop detection.
module io_bus_bridge #(
   parameter int TX_DEPTH_LOG = 4,
   parameter int FULL_MARGIN  = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [16:0] ram_a,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        halted,
   output logic        tx_overflow
);

   localparam int DEPTH = 2 ** TX_DEPTH_LOG;
   localparam int CW    = TX_DEPTH_LOG + 1;
   localparam logic [CW-1:0] DEPTH_CNT  = DEPTH[CW-1:0];
   localparam logic [CW-1:0] MARGIN_CNT = FULL_MARGIN[CW-1:0];
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [TX_DEPTH_LOG-1:0] PTR_ONE = {{(TX_DEPTH_LOG-1){1'b0}}, 1'b1};

   localparam logic [17:0] ADDR_UART = 18'h30000;
   localparam logic [17:0] ADDR_STOP = 18'h30004;
   localparam logic [17:0] ADDR_CNT1 = 18'h30005;
   localparam logic [17:0] ADDR_CNT2 = 18'h30006;
   localparam logic [17:0] ADDR_CNT3 = 18'h30007;

   typedef enum logic [1:0] {RD_RAM, RD_IO_RX, RD_CNT} rdSel_t;

   rdSel_t                rdSel_q, rdSel_d;
   logic [7:0]            ioRdata_q, ioRdata_d;
   logic [31:0]           counter_q, counter_d;
   logic [31:0]           snapshot_q, snapshot_d;
   logic [CW-1:0]         count_q, count_d;
   logic [TX_DEPTH_LOG-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic                  haltedFlag_q, haltedFlag_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            fifoMem_q [DEPTH];

   logic [17:0] addr;
   logic        isIo;
   logic        ioWrite;
   logic        pushReq;
   logic        popReq;
   logic        doPush;
   logic [7:0]  pushByte;
   logic [CW-1:0] freeCnt;

   assign addr      = mem_a[17:0];
   assign isIo      = (addr[17:16] == 2'b11);
   assign ram_a     = mem_a[16:0];
   assign ram_wdata = mem_dout;
   assign ram_we    = rdy_in & mem_wr & ~isIo & ~haltedFlag_q;

   // The stop write always queues a 0x00 so the console sees a terminator.
   assign ioWrite  = rdy_in & mem_wr & isIo & ~haltedFlag_q;
   assign pushReq  = ioWrite & (((addr == ADDR_UART) & (mem_dout != 8'h00)) | (addr == ADDR_STOP));
   assign pushByte = (addr == ADDR_STOP) ? 8'h00 : mem_dout;
   assign tx_valid = (count_q != '0);
   assign tx_data  = fifoMem_q[rdPtr_q];
   assign popReq   = tx_valid & tx_ready;
   assign doPush   = pushReq & ((count_q != DEPTH_CNT) | popReq);
   assign freeCnt  = DEPTH_CNT - count_q;

   assign io_buffer_full = (freeCnt <= MARGIN_CNT);
   assign halted         = haltedFlag_q & (count_q == '0);
   assign tx_overflow    = overflow_q;
   assign rx_pop         = rdy_in & ~mem_wr & (addr == ADDR_UART) & rx_valid;
   assign mem_din        = (rdSel_q == RD_RAM) ? ram_rdata : ioRdata_q;

   always_comb begin
      rdSel_d      = rdSel_q;
      ioRdata_d    = ioRdata_q;
      counter_d    = counter_q;
      snapshot_d   = snapshot_q;
      count_d      = count_q;
      wrPtr_d      = wrPtr_q;
      rdPtr_d      = rdPtr_q;
      haltedFlag_d = haltedFlag_q;
      overflow_d   = overflow_q;

      if (popReq) rdPtr_d = rdPtr_q + PTR_ONE;
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPush & ~popReq) count_d = count_q + CNT_ONE;
      else if (~doPush & popReq) count_d = count_q - CNT_ONE;
      if (pushReq & ~doPush) overflow_d = 1'b1;
      if (ioWrite & (addr == ADDR_STOP)) haltedFlag_d = 1'b1;

      if (rdy_in) begin
         counter_d = counter_q + 32'd1;
         if (!isIo) rdSel_d = RD_RAM;
         else if ((addr >= ADDR_STOP) && (addr <= ADDR_CNT3)) rdSel_d = RD_CNT;
         else rdSel_d = RD_IO_RX;

         // Byte 0 comes from the live counter; bytes 1..3 from the frozen snapshot.
         if (isIo & ~mem_wr) begin
            case (addr)
               ADDR_UART: ioRdata_d = rx_valid ? rx_data : 8'h00;
               ADDR_STOP: begin
                  snapshot_d = counter_q;
                  ioRdata_d  = counter_q[7:0];
               end
               ADDR_CNT1: ioRdata_d = snapshot_q[15:8];
               ADDR_CNT2: ioRdata_d = snapshot_q[23:16];
               ADDR_CNT3: ioRdata_d = snapshot_q[31:24];
               default:   ioRdata_d = 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rdSel_q      <= RD_RAM;
         ioRdata_q    <= 8'h00;
         counter_q    <= 32'd0;
         snapshot_q   <= 32'd0;
         count_q      <= '0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         haltedFlag_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         rdSel_q      <= rdSel_d;
         ioRdata_q    <= ioRdata_d;
         counter_q    <= counter_d;
         snapshot_q   <= snapshot_d;
         count_q      <= count_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         haltedFlag_q <= haltedFlag_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (doPush) fifoMem_q[wrPtr_q] <= pushByte;
   end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: directed scenarios plus random traffic
// compared against a queue/array reference model of the bridge.
module tb_io_bus_bridge;

   localparam int DEPTH  = 16;
   localparam int MARGIN = 2;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic [31:0] mem_a = 32'h0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_dout = 8'h0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [16:0] ram_a;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h0;
   logic        rx_valid = 1'b0;
   logic        rx_pop;
   logic        halted;
   logic        tx_overflow;

   int checks = 0;
   int errors = 0;

   io_bus_bridge #(.TX_DEPTH_LOG(4), .FULL_MARGIN(MARGIN)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
      .io_buffer_full(io_buffer_full),
      .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .halted(halted), .tx_overflow(tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // Environment RAM with one-cycle read latency (aliased to 512 bytes).
   logic [7:0] envRam [512];
   always @(posedge clk_in) begin
      if (ram_we) envRam[ram_a[8:0]] <= ram_wdata;
      ram_rdata <= envRam[ram_a[8:0]];
   end

   // Reference model state
   logic [7:0]  mq[$];
   bit          mOverflow;
   bit          mHalted;
   logic [31:0] mCnt;
   logic [31:0] mSnap;
   logic [7:0]  mRam [512];
   bit          mRamValid [512];
   logic [7:0]  expDin;
   bit          dinValid;

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkComb();
      logic [17:0] a18;
      bit io;
      a18 = mem_a[17:0];
      io  = (a18[17:16] == 2'b11);
      check("ram_we", 32'(ram_we), 32'(rdy_in && mem_wr && !io && !mHalted));
      check("rx_pop", 32'(rx_pop), 32'(rdy_in && !mem_wr && a18 == 18'h30000 && rx_valid));
      if (rdy_in) check("ram_a", 32'(ram_a), 32'(mem_a[16:0]));
   endtask

   task automatic modelStep();
      logic [17:0] a18;
      bit io, live, pop, push;
      int sizeBefore;
      logic [7:0] pb;
      a18 = mem_a[17:0];
      io = (a18[17:16] == 2'b11);
      live = rdy_in;
      sizeBefore = mq.size();
      pop = (sizeBefore != 0) && tx_ready;
      push = 1'b0;
      pb = 8'h00;
      if (live && mem_wr && !mHalted) begin
         if (io) begin
            if (a18 == 18'h30000 && mem_dout != 8'h00) begin push = 1'b1; pb = mem_dout; end
            else if (a18 == 18'h30004) begin push = 1'b1; pb = 8'h00; mHalted = 1'b1; end
         end else begin
            mRam[a18[8:0]] = mem_dout;
            mRamValid[a18[8:0]] = 1'b1;
         end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         if (sizeBefore < DEPTH || pop) mq.push_back(pb);
         else mOverflow = 1'b1;
      end
      dinValid = 1'b0;
      if (live && !mem_wr) begin
         if (!io) begin
            dinValid = mRamValid[a18[8:0]];
            expDin = mRam[a18[8:0]];
         end else begin
            dinValid = 1'b1;
            case (a18)
               18'h30000: expDin = rx_valid ? rx_data : 8'h00;
               18'h30004: begin mSnap = mCnt; expDin = mCnt[7:0]; end
               18'h30005: expDin = mSnap[15:8];
               18'h30006: expDin = mSnap[23:16];
               18'h30007: expDin = mSnap[31:24];
               default:   expDin = 8'h00;
            endcase
         end
      end
      if (live) mCnt = mCnt + 32'd1;
   endtask

   task automatic checkOutput();
      int sz;
      sz = mq.size();
      check("tx_valid", 32'(tx_valid), 32'(sz != 0));
      if (sz != 0) check("tx_data", 32'(tx_data), 32'(mq[0]));
      check("io_buffer_full", 32'(io_buffer_full), 32'((DEPTH - sz) <= MARGIN));
      check("halted", 32'(halted), 32'(mHalted && sz == 0));
      check("tx_overflow", 32'(tx_overflow), 32'(mOverflow));
      if (dinValid) check("mem_din", 32'(mem_din), 32'(expDin));
   endtask

   task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
      @(negedge clk_in);
      rdy_in = r; mem_a = a; mem_wr = w; mem_dout = d;
      #1;
      checkComb();
      modelStep();
      @(posedge clk_in);
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b1, 32'h0, 1'b0, 8'h00);
   endtask

   task automatic doReset();
      @(negedge clk_in);
      rst_in = 1'b0; rdy_in = 1'b0; mem_wr = 1'b0;
      #1;
      mq.delete();
      mOverflow = 1'b0; mHalted = 1'b0; mCnt = 32'd0; mSnap = 32'd0; dinValid = 1'b0;
      checkOutput();
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   function automatic logic [31:0] randRamAddr();
      logic [31:0] r;
      r = $urandom;
      r[17:16] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   function automatic logic [31:0] ioAddr(input logic [17:0] low);
      logic [31:0] r;
      r = $urandom;
      r[17:0] = low;
      return r;
   endfunction

   initial begin
      for (int i = 0; i < 512; i++) begin
         mRamValid[i] = 1'b0;
         mRam[i] = 8'h00;
      end
      doReset();

      // Single UART byte, then a filtered zero byte
      tx_ready = 1'b1;
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h41);
      idle(2);
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h00);
      idle(1);

      // Fill FIFO past capacity with the UART stalled
      tx_ready = 1'b0;
      for (int i = 0; i < 17; i++)
         applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'(i + 1));
      tx_ready = 1'b1;
      for (int i = 0; i < 40 && mq.size() != 0; i++) idle(1);
      idle(1);

      // RAM write then read-back
      applyStimulus(1'b1, 32'h00000100, 1'b1, 8'h5A);
      applyStimulus(1'b1, 32'h00000100, 1'b0, 8'h00);
      idle(1);

      // Cycle counter snapshot, then freeze with rdy low
      doReset();
      idle(999);
      applyStimulus(1'b1, ioAddr(18'h30004), 1'b0, 8'h00);
      applyStimulus(1'b1, ioAddr(18'h30005), 1'b0, 8'h00);
      applyStimulus(1'b1, ioAddr(18'h30006), 1'b0, 8'h00);
      applyStimulus(1'b1, ioAddr(18'h30007), 1'b0, 8'h00);
      repeat (10) applyStimulus(1'b0, ioAddr(18'h30004), 1'b0, 8'h00);
      applyStimulus(1'b1, ioAddr(18'h30004), 1'b0, 8'h00);

      // Console input with and without a pending byte
      rx_valid = 1'b1; rx_data = 8'h33;
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b0, 8'h00);
      rx_valid = 1'b0;
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b0, 8'h00);
      applyStimulus(1'b1, ioAddr(18'h30009), 1'b0, 8'h00);

      // Random traffic (stop writes excluded so the bus stays usable)
      for (int n = 0; n < 400; n++) begin
         int kind;
         tx_ready = 1'($urandom_range(0, 1));
         rx_valid = 1'($urandom_range(0, 1));
         rx_data  = 8'($urandom);
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1, 2: applyStimulus(1'b1, randRamAddr(), 1'b1, 8'($urandom));
            3, 4:    applyStimulus(1'b1, randRamAddr(), 1'b0, 8'h00);
            5:       applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'($urandom_range(0, 3)));
            6:       applyStimulus(1'b1, ioAddr(18'h30000), 1'b0, 8'h00);
            7:       applyStimulus(1'b1, ioAddr(18'(18'h30004 + 18'($urandom_range(0, 3)))), 1'b0, 8'h00);
            8:       applyStimulus(1'b1, ioAddr(($urandom_range(0, 1) == 0) ? 18'h30008 : 18'h3FFFF),
                                   1'($urandom_range(0, 1)), 8'($urandom));
            default: applyStimulus(1'b0, randRamAddr(), 1'($urandom_range(0, 1)), 8'($urandom));
         endcase
      end
      rx_valid = 1'b0;

      // Stop with two bytes pending, drain to halted
      doReset();
      tx_ready = 1'b0;
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h11);
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h22);
      applyStimulus(1'b1, ioAddr(18'h30004), 1'b1, 8'hFF);
      applyStimulus(1'b1, 32'h00000020, 1'b1, 8'h77);
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h99);
      tx_ready = 1'b1;
      idle(6);

      // Reset while the FIFO is still draining
      doReset();
      tx_ready = 1'b0;
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h55);
      applyStimulus(1'b1, ioAddr(18'h30000), 1'b1, 8'h66);
      applyStimulus(1'b1, ioAddr(18'h30004), 1'b1, 8'h00);
      tx_ready = 1'b1;
      idle(1);
      doReset();
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits directly downstream of the cpu memory bus (mem_a/mem_wr/mem_dout/mem_din/io_buffer_full).
- Splits each byte access between the 128 KB RAM and the memory-mapped I/O region (mem_a[17:16]==2'b11).
- Buffers UART output bytes in a FIFO, serves console input and the cycle counter, and flags program stop.
- Generates io_buffer_full back to the cpu.

Parameters:
TX_DEPTH_LOG, 4, log2 of TX FIFO depth (16 entries)
FULL_MARGIN, 2, io_buffer_full asserts when free entries <= FULL_MARGIN (covers writes already in flight)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  cpu ready; bus ignored and counter frozen when low
mem_a  in  32  cpu byte address (bits 17:0 decoded)
mem_wr  in  1  1=write, 0=read
mem_dout  in  8  write byte from cpu
mem_din  out  8  read byte to cpu, valid one cycle after the request
io_buffer_full  out  1  TX FIFO nearly full
ram_a  out  17  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read byte, one-cycle latency
tx_data  out  8  UART transmit byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts byte when tx_valid & tx_ready
rx_data  in  8  UART received byte
rx_valid  in  1  rx_data valid
rx_pop  out  1  one-cycle pulse consuming rx_data
halted  out  1  program stop seen and TX FIFO drained
tx_overflow  out  1  sticky: a write was dropped on a full FIFO

Behaviour:
- Decode: is_io = mem_a[17:16]==2'b11. An access is live only when rdy_in=1.
- RAM path (combinational):
  - ram_a = mem_a[16:0]; ram_wdata = mem_dout.
  - ram_we = rdy_in & mem_wr & ~is_io & ~halted_flag.
- Read-return mux:
  - Register rd_sel each live cycle: RAM, IO_RX, or CNT.
  - Next cycle, mem_din = ram_rdata when rd_sel=RAM, otherwise the registered io_rdata.
  - When rdy_in=0, rd_sel and io_rdata hold.
- IO writes (live, is_io, mem_wr):
  - Address 0x30000 with a nonzero byte: push to the TX FIFO.
  - Address 0x30000 with byte 0x00: ignored.
  - Address 0x30004: push 0x00 (this push is never filtered) and set halted_flag.
  - Other IO addresses: ignored.
  - After halted_flag is set, all writes (RAM and IO) are ignored.
- IO reads:
  - 0x30000: if rx_valid, io_rdata <= rx_data and rx_pop pulses in the same cycle as the request; otherwise io_rdata <= 0x00 and there is no pop.
  - 0x30004: snapshot <= cycle counter; io_rdata <= counter[7:0].
  - 0x30005..0x30007: io_rdata <= snapshot byte 1..3.
  - Other IO addresses: read 0x00.
- Cycle counter:
  - 32-bit, +1 every cycle with rdy_in=1, wraps 0xFFFFFFFF->0.
  - Reads at 0x30004 capture the pre-increment value.
- TX FIFO:
  - Circular buffer, 2^TX_DEPTH_LOG entries; TX_DEPTH_LOG+1-bit count.
  - tx_valid = count!=0; tx_data = head entry; pop on tx_valid & tx_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance; legal even when full.
  - Push when full with no pop: byte dropped, tx_overflow set (sticky until reset).
  - Pointers wrap modulo depth.
  - io_buffer_full = (depth - count) <= FULL_MARGIN, combinational from count.
- halted = halted_flag & (count==0).
- Reset (async, rst_in=0), all values:
  - count=0, pointers=0, counter=0, snapshot=0, io_rdata=0, rd_sel=RAM.
  - halted_flag=0, tx_overflow=0, rx_pop=0.
  - Outputs therefore: tx_valid=0, io_buffer_full=0, halted=0, mem_din=ram_rdata.
- Reset mid-operation: FIFO contents are discarded and no pending byte is emitted; de-assertion resumes from the state above.

Test Plan:
- Write 0x41 to 0x30000 with tx_ready=1 -> tx_valid=1 with tx_data=0x41 one cycle later, FIFO empty after pop; write 0x00 to 0x30000 -> no push.
- Hold tx_ready=0 and write 14 bytes -> io_buffer_full rises after the 14th push (free=2); 3 more writes -> 16 entries stored, 17th dropped, tx_overflow=1; release tx_ready -> bytes emerge in order, io_buffer_full falls at free=3.
- RAM write 0x5A to 0x00100, then read 0x00100 -> ram_we pulses once, and mem_din=0x5A the cycle after the read request.
- After 1000 rdy cycles, read 0x30004..0x30007 -> the four bytes equal the snapshot value (999 counted before that cycle) even though the counter advances meanwhile; toggling rdy_in=0 for 10 cycles leaves the counter frozen.
- rx_valid=1 with rx_data=0x33, read 0x30000 -> rx_pop pulses once, mem_din=0x33 next cycle; rx_valid=0 -> returns 0x00, no pop.
- Write to 0x30004 with 2 bytes pending -> 0x00 queued third, subsequent RAM writes are blocked, halted rises only after the FIFO drains; assert rst_in=0 mid-drain -> tx_valid=0 immediately and halted=0.
